// File: rtl/datapath_reg_alu.sv
// 64-bit single-cycle datapath slice: 32x64 register file, ALU with status flags,
// and a word-addressed data RAM. All three share one 64-bit result bus, which is
// written back to the register file on the rising clock edge.
module datapath_reg_alu #(
  parameter int unsigned MEM_DEPTH     = 256,
  parameter int unsigned MEM_ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  DA,
  input  logic [4:0]  SA,
  input  logic [4:0]  SB,
  input  logic        W,
  input  logic [63:0] K,
  input  logic        BS,
  input  logic [4:0]  FS,
  input  logic        write,
  input  logic        selEN,
  output logic [3:0]  status,
  output logic [63:0] data
);

  localparam logic [4:0] ZeroReg = 5'd31;

  // ALU function codes carried in FS[4:2]
  localparam logic [2:0] FnAnd = 3'b000;
  localparam logic [2:0] FnOr  = 3'b001;
  localparam logic [2:0] FnAdd = 3'b010;
  localparam logic [2:0] FnXor = 3'b011;
  localparam logic [2:0] FnShl = 3'b100;
  localparam logic [2:0] FnShr = 3'b101;

  // Register file storage; entry 31 is never written and always reads as zero
  logic [63:0] rf_q [32];

  // Data RAM storage; deliberately not cleared by reset
  logic [63:0] mem_q [MEM_DEPTH];

  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [63:0] op_b;
  logic [63:0] a_p;
  logic [63:0] b_p;
  logic [64:0] add_sum;
  logic [63:0] alu_f;
  logic        alu_c;
  logic        alu_v;
  logic        is_add;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [63:0] mem_rdata;

  // Combinational register reads with R31 hard-wired to zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (SA != ZeroReg) begin
      rd_a = rf_q[SA];
    end
    if (SB != ZeroReg) begin
      rd_b = rf_q[SB];
    end
  end

  // Operand selection and optional inversion feeding the ALU
  always_comb begin
    op_b = BS ? K : rd_b;
    a_p  = FS[1] ? ~rd_a : rd_a;
    b_p  = FS[0] ? ~op_b : op_b;
  end

  // Shared adder: FS[0] doubles as carry-in so that 01001 computes A-B
  always_comb begin
    add_sum = {1'b0, a_p} + {1'b0, b_p} + {64'd0, FS[0]};
  end

  // ALU function decode; carry and overflow only meaningful for ADD
  always_comb begin
    alu_f  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    is_add = 1'b0;
    unique case (FS[4:2])
      FnAnd: alu_f = a_p & b_p;
      FnOr:  alu_f = a_p | b_p;
      FnAdd: begin
        is_add = 1'b1;
        alu_f  = add_sum[63:0];
        alu_c  = add_sum[64];
        // Signed overflow: like-signed operands producing an opposite-signed sum
        alu_v  = (a_p[63] == b_p[63]) && (add_sum[63] != a_p[63]);
      end
      FnXor: alu_f = a_p ^ b_p;
      // Shifts use the unmodified B source; only the low six bits count
      FnShl: alu_f = rd_a << op_b[5:0];
      FnShr: alu_f = rd_a >> op_b[5:0];
      default: alu_f = '0;
    endcase
  end

  // Status flags packed as {V, C, N, Z}
  always_comb begin
    status = {alu_v & is_add, alu_c & is_add, alu_f[63], (alu_f == 64'd0)};
  end

  // RAM is word-addressed by the low bits of the ALU result; read is asynchronous
  always_comb begin
    mem_addr  = alu_f[MEM_ADDR_BITS-1:0];
    mem_rdata = mem_q[mem_addr];
  end

  // Result bus: ALU result or RAM read data, no pipeline stage
  always_comb begin
    data = selEN ? alu_f : mem_rdata;
  end

  // Register write-back; async reset clears the whole file, R31 never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (W && (DA != ZeroReg)) begin
      rf_q[DA] <= data;
    end
  end

  // RAM write of register B (never K); reads in the same cycle see old contents
  always_ff @(posedge clock) begin
    if (write) begin
      mem_q[mem_addr] <= rd_b;
    end
  end

endmodule

// File: tb/tb_datapath_reg_alu.sv
// Directed bench for datapath_reg_alu: hand-computed vectors covering write-back,
// ALU functions, flags, RAM read/write ordering, R31 behaviour and async reset.
module tb_datapath_reg_alu;

  logic        clock;
  logic        reset;
  logic [4:0]  DA;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic        W;
  logic [63:0] K;
  logic        BS;
  logic [4:0]  FS;
  logic        write;
  logic        selEN;
  logic [3:0]  status;
  logic [63:0] data;

  int errors;
  int checks;

  datapath_reg_alu #(
    .MEM_DEPTH    (256),
    .MEM_ADDR_BITS(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .DA    (DA),
    .SA    (SA),
    .SB    (SB),
    .W     (W),
    .K     (K),
    .BS    (BS),
    .FS    (FS),
    .write (write),
    .selEN (selEN),
    .status(status),
    .data  (data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                       input logic w, input logic [63:0] k, input logic bs,
                       input logic [4:0] fs, input logic wr, input logic sel);
    DA = da; SA = sa; SB = sb; W = w; K = k; BS = bs; FS = fs; write = wr; selEN = sel;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    W = 1'b0;
    write = 1'b0;
  endtask

  // Read a register through the ALU as (R[r] | 0)
  task automatic read_reg(input logic [4:0] r, input string tag, input logic [63:0] exp);
    drive(5'd0, r, 5'd0, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b1);
    check(tag, data, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b1);
    #6;
    check("reset_data", data, 64'd0);
    check("reset_status", {60'd0, status}, 64'h1);
    reset = 1'b0;
    tick();

    // 1: pass K into R5 and R7
    drive(5'd5, 5'd31, 5'd0, 1'b1, 64'd24, 1'b1, 5'b00100, 1'b0, 1'b1);
    check("t1_data", data, 64'd24);
    tick();
    drive(5'd7, 5'd31, 5'd0, 1'b1, 64'd39, 1'b1, 5'b00100, 1'b0, 1'b1);
    tick();
    read_reg(5'd5, "t1_r5", 64'd24);
    read_reg(5'd7, "t1_r7", 64'd39);

    // 2: add and xor
    drive(5'd1, 5'd5, 5'd7, 1'b1, 64'd0, 1'b0, 5'b01000, 1'b0, 1'b1);
    check("t2_add", data, 64'd63);
    check("t2_status", {60'd0, status}, 64'h0);
    tick();
    read_reg(5'd1, "t2_r1", 64'd63);
    drive(5'd30, 5'd1, 5'd5, 1'b1, 64'd0, 1'b0, 5'b01100, 1'b0, 1'b1);
    tick();
    read_reg(5'd30, "t2_r30", 64'd39);

    // 3: shift left, plus shift right and zero-shift boundary
    drive(5'd17, 5'd30, 5'd0, 1'b1, 64'd2, 1'b1, 5'b10000, 1'b0, 1'b1);
    tick();
    read_reg(5'd17, "t3_r17", 64'd156);
    drive(5'd0, 5'd17, 5'd0, 1'b0, 64'd2, 1'b1, 5'b10100, 1'b0, 1'b1);
    check("t3_shr", data, 64'd39);
    drive(5'd0, 5'd17, 5'd0, 1'b0, 64'd0, 1'b1, 5'b10100, 1'b0, 1'b1);
    check("t3_shift0", data, 64'd156);
    drive(5'd0, 5'd17, 5'd0, 1'b0, 64'd5, 1'b1, 5'b11000, 1'b0, 1'b1);
    check("t3_fn110", data, 64'd0);

    // 4: store R17 to M[39], then load it into R0
    drive(5'd2, 5'd7, 5'd17, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b1, 1'b0);
    tick();
    read_reg(5'd2, "t4_no_reg_write", 64'd0);
    drive(5'd0, 5'd7, 5'd17, 1'b1, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b0);
    check("t4_load", data, 64'd156);
    tick();
    read_reg(5'd0, "t4_r0", 64'd156);
    // Overwrite M[39] with R30: old value visible during the write cycle
    drive(5'd0, 5'd7, 5'd30, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b1, 1'b0);
    check("t4_old_read", data, 64'd156);
    tick();
    drive(5'd0, 5'd7, 5'd30, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b0);
    check("t4_new_read", data, 64'd39);

    // 5: subtract equal values, signed overflow, R31 write ignored
    drive(5'd0, 5'd5, 5'd5, 1'b0, 64'd0, 1'b0, 5'b01001, 1'b0, 1'b1);
    check("t5_sub", data, 64'd0);
    check("t5_sub_status", {60'd0, status}, 64'h5);
    drive(5'd2, 5'd31, 5'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 5'b00100, 1'b0, 1'b1);
    tick();
    drive(5'd0, 5'd2, 5'd0, 1'b0, 64'd1, 1'b1, 5'b01000, 1'b0, 1'b1);
    check("t5_ovf_data", data, 64'h8000_0000_0000_0000);
    check("t5_ovf_status", {60'd0, status}, 64'hA);
    drive(5'd31, 5'd31, 5'd0, 1'b1, 64'd123, 1'b1, 5'b00100, 1'b0, 1'b1);
    check("t5_bus_123", data, 64'd123);
    tick();
    read_reg(5'd31, "t5_r31", 64'd0);

    // 6: asynchronous reset mid-cycle
    drive(5'd3, 5'd31, 5'd0, 1'b1, 64'hAA, 1'b1, 5'b00100, 1'b0, 1'b1);
    tick();
    read_reg(5'd3, "t6_r3_loaded", 64'hAA);
    #1;
    reset = 1'b1;
    #1;
    check("t6_r3_reset", data, 64'd0);
    read_reg(5'd5, "t6_r5_reset", 64'd0);
    reset = 1'b0;
    #1;
    drive(5'd0, 5'd31, 5'd0, 1'b0, 64'd39, 1'b1, 5'b00100, 1'b0, 1'b0);
    check("t6_ram_kept", data, 64'd39);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
